// File: rtl/earth_pkg.sv
// Shared definitions for the earth_top token-buffer path: requester ids,
// arbiter state encoding and default token-buffer geometry.
package earth_pkg;

  localparam int REQ_DRAM = 0;
  localparam int REQ_DISP = 1;
  localparam int REQ_COL  = 2;
  localparam int REQ_GATE = 3;

  localparam int TBUF_ADDR_W = 8;
  localparam int TBUF_DATA_W = 1024;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tbuf_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req starting at ptr,
// skipping requesters set in excl; returns a one-hot grant and a found flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     gnt,
  output logic             found
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single subtraction wraps the index
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N)) begin
        sum = sum - (PTR_W + 1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx] && !excl[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbuf_port_arbiter.sv
// Token-buffer port arbiter: round-robin with burst locking, registered
// buffer requests and read-return routing. Optional counters: TBUF_ARB_PERF_EN.
module tbuf_port_arbiter
  import earth_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = TBUF_ADDR_W,
  parameter int DATA_W    = TBUF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     buf_req,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [DATA_W-1:0]        buf_wdata,
  input  logic [DATA_W-1:0]        buf_rdata,
  output arb_state_e               dbg_state
`ifdef TBUF_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]      perf_grant_cnt,
  output logic [N_REQ*32-1:0]      perf_stall_cnt
`endif
);

  // Handshake: a beat moves when req[i] && gnt[i]; the requester holds
  // req/we/addr/wdata stable until granted, and gnt is at most one-hot.

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] id;
  } rd_tag_t;

  arb_state_e         state;
  logic [PTR_W-1:0]   owner;
  logic [BURST_W-1:0] burst_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   excl_q;

  logic [N_REQ-1:0]   pick_excl;
  logic [N_REQ-1:0]   pick_gnt;
  logic               pick_found;
  logic [N_REQ-1:0]   owner_mask;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               gnt_read;

  rd_tag_t            rd_pipe [RD_LAT];

  assign dbg_state  = state;
  assign rdata      = buf_rdata;
  assign owner_mask = N_REQ'(1) << owner;

  // The post-burst exclusion only applies while someone else is waiting
  always_comb begin
    pick_excl = '0;
    if ((req & ~excl_q) != '0) begin
      pick_excl = excl_q;
    end
  end

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .excl  (pick_excl),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state == LOCKED) begin
        gnt = req & owner_mask;
      end else if (pick_found) begin
        gnt = pick_gnt;
      end
    end
  end

  always_comb begin
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PTR_W'(i);
        sel_addr  = sel_addr  | addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | wdata[i*DATA_W +: DATA_W];
      end
    end
    gnt_read = |(gnt & ~we);
    next_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Buffer request register and read-tag pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_req   <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      rvalid    <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_pipe[k] <= '0;
      end
    end else begin
      buf_req    <= |gnt;
      buf_we     <= |(gnt & we);
      buf_addr   <= sel_addr;
      buf_wdata  <= sel_wdata;
      rd_pipe[0] <= '{valid: gnt_read, id: gnt_idx};
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end
      rvalid <= rd_pipe[RD_LAT-1].valid ? (N_REQ'(1) << rd_pipe[RD_LAT-1].id) : '0;
    end
  end

  // Arbitration FSM; the pointer only advances on ARB grants
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      excl_q    <= '0;
    end else begin
      case (state)
        ARB: begin
          excl_q <= '0;
          if (|gnt) begin
            rr_ptr <= next_ptr;
            if (lock[gnt_idx]) begin
              if (MAX_BURST > 1) begin
                state     <= LOCKED;
                owner     <= gnt_idx;
                burst_cnt <= BURST_W'(1);
              end else begin
                excl_q <= gnt;
              end
            end
          end
        end
        LOCKED: begin
          if (req[owner]) begin
            if (!lock[owner]) begin
              state     <= ARB;
              burst_cnt <= '0;
            end else if (burst_cnt == BURST_W'(MAX_BURST - 1)) begin
              state     <= ARB;
              burst_cnt <= '0;
              excl_q    <= owner_mask;
            end else begin
              burst_cnt <= burst_cnt + BURST_W'(1);
            end
          end else begin
            state     <= ARB;
            burst_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef TBUF_ARB_PERF_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    logic [31:0] grant_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else begin
        if (gnt[g] && (grant_cnt != 32'hFFFF_FFFF)) begin
          grant_cnt <= grant_cnt + 32'd1;
        end
        if (req[g] && !gnt[g] && (stall_cnt != 32'hFFFF_FFFF)) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end
    end

    assign perf_grant_cnt[g*32 +: 32] = grant_cnt;
    assign perf_stall_cnt[g*32 +: 32] = stall_cnt;
  end
`endif

endmodule
